// File: rtl/count_step_ctrl.sv
// Burst sequencer for a multiple-step accumulating counter: issues n_steps enable pulses of size step.
// Define COUNT_STEP_CHECK_EN to include the expected-sum accumulator and the end-of-burst compare (err).
module count_step_ctrl #(
  parameter int BIT_SZ = 10,
  parameter int GAP    = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [BIT_SZ-1:0] step,
  input  logic [7:0]        n_steps,
  input  logic              hold,
  input  logic [BIT_SZ-1:0] count_in,
  output logic              cnt_enable,
  output logic [BIT_SZ-1:0] cnt_multiple,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        steps_left
);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_CHECK} state_t;

  // Gap counter is loaded with GAP-1 and runs down to 0, giving exactly GAP idle cycles.
  localparam logic [7:0] GAP_LAST = 8'((GAP > 0) ? GAP - 1 : 0);

  state_t            state_q, state_d;
  logic [BIT_SZ-1:0] step_q, step_d;
  logic [7:0]        left_q, left_d;
  logic [7:0]        gap_q, gap_d;
  logic              fire;
`ifdef COUNT_STEP_CHECK_EN
  logic [BIT_SZ-1:0] exp_q, exp_d;
  logic              err_q, err_d;
`else
  logic              unused_count_in;
  assign unused_count_in = ^count_in;
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    left_d  = left_q;
    gap_d   = gap_q;
    fire    = 1'b0;
`ifdef COUNT_STEP_CHECK_EN
    exp_d   = exp_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          step_d  = step;
          left_d  = n_steps;
          state_d = (n_steps != 8'd0) ? S_PULSE : S_CHECK;
`ifdef COUNT_STEP_CHECK_EN
          exp_d   = count_in;
          err_d   = 1'b0;
`endif
        end
      end
      S_PULSE: begin
        if (!hold) begin
          fire   = 1'b1;
          left_d = left_q - 8'd1;
`ifdef COUNT_STEP_CHECK_EN
          exp_d  = exp_q + step_q;
`endif
          if (left_q == 8'd1) begin
            state_d = S_CHECK;
          end else if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LAST;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 8'd0) state_d = S_PULSE;
        else               gap_d   = gap_q - 8'd1;
      end
      S_CHECK: begin
        // count_in already includes the last pulse here: the counter updated at the previous edge.
        state_d = S_IDLE;
`ifdef COUNT_STEP_CHECK_EN
        err_d   = (count_in != exp_q);
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      left_q  <= '0;
      gap_q   <= '0;
`ifdef COUNT_STEP_CHECK_EN
      exp_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      left_q  <= left_d;
      gap_q   <= gap_d;
`ifdef COUNT_STEP_CHECK_EN
      exp_q   <= exp_d;
      err_q   <= err_d;
`endif
    end
  end

  // Enable is combinational on hold so a held PULSE cycle issues nothing.
  assign cnt_enable   = fire;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_CHECK);
  assign cnt_multiple = busy ? step_q : '0;
  assign steps_left   = left_q;
`ifdef COUNT_STEP_CHECK_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_count_step_ctrl.sv
// Bench for count_step_ctrl: two instances (GAP=0 and GAP=2) share stimulus; each drives its own counter model.
module tb_count_step_ctrl;

`ifdef COUNT_STEP_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] step_in = '0;
  logic [7:0] n_in = '0;
  logic       hold = 1'b0;
  logic       load = 1'b0;
  logic [9:0] lv = '0;
  logic       inj = 1'b0;
  bit         mv = 1'b0;

  logic       en  [2];
  logic [9:0] mul [2];
  logic       bsy [2];
  logic       dn  [2];
  logic       er  [2];
  logic [7:0] sl  [2];
  logic [9:0] cin [2];
  logic [9:0] cnt [2];

  // Abstract model: per instance, pulses remaining, cycles since last pulse, running sum.
  bit         m_busy  [2];
  bit         m_chk   [2];
  bit         m_err   [2];
  logic [9:0] m_step  [2];
  logic [9:0] m_exp   [2];
  int         m_left  [2];
  int         m_since [2];

  int n_pass = 0;
  int n_tot  = 0;
  logic [31:0] pm [2];
  int          dc [2];

  always #5 clk = ~clk;

  count_step_ctrl #(.BIT_SZ(10), .GAP(0)) dut0 (
    .clock(clk), .reset(rst), .start(start), .step(step_in), .n_steps(n_in), .hold(hold),
    .count_in(cin[0]), .cnt_enable(en[0]), .cnt_multiple(mul[0]), .busy(bsy[0]),
    .done(dn[0]), .err(er[0]), .steps_left(sl[0]));

  count_step_ctrl #(.BIT_SZ(10), .GAP(2)) dut2 (
    .clock(clk), .reset(rst), .start(start), .step(step_in), .n_steps(n_in), .hold(hold),
    .count_in(cin[1]), .cnt_enable(en[1]), .cnt_multiple(mul[1]), .busy(bsy[1]),
    .done(dn[1]), .err(er[1]), .steps_left(sl[1]));

  assign cin[0] = cnt[0] + 10'(inj & m_busy[0] & m_chk[0]);
  assign cin[1] = cnt[1] + 10'(inj & m_busy[1] & m_chk[1]);

  function automatic int gv(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic bit m_en(input int i);
    return m_busy[i] && !m_chk[i] && (m_since[i] > gv(i)) && !hold;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (load)       cnt[i] <= lv;
      else if (en[i]) cnt[i] <= cnt[i] + mul[i];
      if (rst) begin
        m_busy[i] <= 0; m_chk[i] <= 0; m_err[i] <= 0; m_step[i] <= '0;
        m_exp[i] <= '0; m_left[i] <= 0; m_since[i] <= 0;
      end else if (!m_busy[i]) begin
        if (start) begin
          m_busy[i] <= 1; m_step[i] <= step_in; m_left[i] <= int'(n_in);
          m_exp[i] <= cin[i]; m_err[i] <= 0; m_since[i] <= 1000;
          m_chk[i] <= (n_in == 8'd0);
        end
      end else if (m_chk[i]) begin
        m_busy[i] <= 0; m_chk[i] <= 0;
        m_err[i] <= CHK_EN && (cin[i] != m_exp[i]);
      end else if (m_en(i)) begin
        m_left[i] <= m_left[i] - 1;
        m_exp[i]  <= m_exp[i] + m_step[i];
        m_since[i] <= 1;
        if (m_left[i] == 1) m_chk[i] <= 1;
      end else if (m_since[i] < 1000) begin
        m_since[i] <= m_since[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("dut%0d cnt_enable", i), int'(en[i]), int'(m_en(i)));
        chk($sformatf("dut%0d cnt_multiple", i), int'(mul[i]), m_busy[i] ? int'(m_step[i]) : 0);
        chk($sformatf("dut%0d busy", i), int'(bsy[i]), int'(m_busy[i]));
        chk($sformatf("dut%0d done", i), int'(dn[i]), int'(m_busy[i] && m_chk[i]));
        chk($sformatf("dut%0d steps_left", i), int'(sl[i]), m_left[i]);
        chk($sformatf("dut%0d err", i), int'(er[i]), int'(m_err[i]));
      end
    end
  end

  task automatic load_cnt(input logic [9:0] v);
    load = 1'b1; lv = v;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic issue(input logic [9:0] s, input logic [7:0] n);
    step_in = s; n_in = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs from cycle 1 until both instances have signalled done; records pulse cycles and done cycle.
  task automatic run(input int hlo, input int hhi, input int bs);
    logic [9:0] orig;
    bit fin;
    orig = step_in; fin = 0;
    pm[0] = '0; pm[1] = '0; dc[0] = -1; dc[1] = -1;
    for (int c = 1; c <= 30; c++) begin
      hold    = (c >= hlo) && (c <= hhi);
      start   = (c == bs);
      step_in = (c == bs) ? 10'd9 : orig;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (en[i]) pm[i][c] = 1'b1;
        if (dn[i] && dc[i] < 0) dc[i] = c;
      end
      @(posedge clk); #1;
      if (dc[0] >= 0 && dc[1] >= 0) begin
        fin = 1;
        break;
      end
    end
    hold = 1'b0; start = 1'b0; step_in = orig;
    chk("burst completes within budget", int'(fin), 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mv = 1'b1;
    chk("reset busy", int'(bsy[0]), 0);
    chk("reset multiple", int'(mul[0]), 0);
    chk("reset steps_left", int'(sl[1]), 0);
    chk("reset err", int'(er[1]), 0);

    // Basic burst: step 3 x 4
    load_cnt(10'd0);
    issue(10'd3, 8'd4);
    run(0, -1, -1);
    chk("basic pulses g0", int'(pm[0]), 32'h1E);
    chk("basic done g0", dc[0], 5);
    chk("basic pulses g2", int'(pm[1]), 32'h492);
    chk("basic done g2", dc[1], 11);
    chk("basic count g0", int'(cnt[0]), 12);
    chk("basic count g2", int'(cnt[1]), 12);
    chk("basic err g0", int'(er[0]), 0);
    chk("basic err g2", int'(er[1]), 0);

    // Gap spacing: step 5 x 3, issued back-to-back with the previous burst
    issue(10'd5, 8'd3);
    run(0, -1, -1);
    chk("gap pulses g2", int'(pm[1]), 32'h92);
    chk("gap done g2", dc[1], 8);
    chk("gap pulses g0", int'(pm[0]), 32'hE);
    chk("gap done g0", dc[0], 4);
    chk("gap count g2", int'(cnt[1]), 27);
    chk("gap count g0", int'(cnt[0]), 27);

    // Wrap-around: 1020 + 10 mod 1024
    load_cnt(10'd1020);
    issue(10'd10, 8'd1);
    run(0, -1, -1);
    chk("wrap done g0", dc[0], 2);
    chk("wrap count g0", int'(cnt[0]), 6);
    chk("wrap count g2", int'(cnt[1]), 6);
    chk("wrap err g0", int'(er[0]), 0);

    // Hold in cycles 2-4, ignored start with step 9 in cycle 3
    load_cnt(10'd0);
    issue(10'd1, 8'd3);
    run(2, 4, 3);
    chk("hold pulses g0", int'(pm[0]), 32'h62);
    chk("hold done g0", dc[0], 7);
    chk("hold pulses g2", int'(pm[1]), 32'h122);
    chk("hold done g2", dc[1], 9);
    chk("hold count g0", int'(cnt[0]), 3);
    chk("hold count g2", int'(cnt[1]), 3);

    // Zero-length burst
    issue(10'd7, 8'd0);
    run(0, -1, -1);
    chk("zero pulses g0", int'(pm[0]), 0);
    chk("zero done g0", dc[0], 1);
    chk("zero pulses g2", int'(pm[1]), 0);
    chk("zero done g2", dc[1], 1);

    // Error injection: count_in off by one during CHECK
    load_cnt(10'd0);
    inj = 1'b1;
    issue(10'd1, 8'd2);
    run(0, -1, -1);
    inj = 1'b0;
    chk("inject err g0", int'(er[0]), int'(CHK_EN));
    chk("inject err g2", int'(er[1]), int'(CHK_EN));

    // Reset in cycle 3 of a step 2 x 8 burst
    issue(10'd2, 8'd8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset busy g0", int'(bsy[0]), 0);
    chk("midreset enable g0", int'(en[0]), 0);
    chk("midreset steps_left g0", int'(sl[0]), 0);
    chk("midreset done g0", int'(dn[0]), 0);
    chk("midreset busy g2", int'(bsy[1]), 0);
    chk("midreset err g0", int'(er[0]), 0);
    repeat (3) @(posedge clk);
    #1;

    mv = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
